// File: rtl/sbox_sched_pkg.sv
// sbox_sched_pkg: shared FSM/grant types, pass-count helper and the AES S-box function.
package sbox_sched_pkg;
  typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_t;
  typedef enum logic {GRANT_ST, GRANT_KW} grant_t;
  function automatic int passes(input int lanes, input int bytes);
    return ((bytes + lanes - 1) / lanes < 1) ? 1 : (bytes + lanes - 1) / lanes;
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // GF(2^8) inverse as x^254 by square-and-multiply, then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/sbox_lane_bank.sv
// sbox_lane_bank: LANES parallel S-boxes, purely combinational.
module sbox_lane_bank import sbox_sched_pkg::*; #(
  parameter int LANES = 4
) (
  input  logic [8*LANES-1:0] i_in,
  output logic [8*LANES-1:0] o_out
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign o_out[8*l +: 8] = sbox(i_in[8*l +: 8]);
  end
endmodule

// File: rtl/sbox_sched.sv
// sbox_sched: shares a LANES-wide S-box bank between a 128-bit SubBytes requester
// and a 32-bit SubWord requester. Define SBOX_SCHED_RR_EN for round-robin ties.
module sbox_sched import sbox_sched_pkg::*; #(
  parameter int LANES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_st_valid,
  output logic         o_st_ready,
  input  logic [127:0] i_st_data,
  output logic         o_st_done,
  output logic [127:0] o_st_data,
  input  logic         i_kw_valid,
  output logic         o_kw_ready,
  input  logic [31:0]  i_kw_word,
  output logic         o_kw_done,
  output logic [31:0]  o_kw_word
);
  localparam int ST_PASSES = passes(LANES, 16);
  localparam int KW_PASSES = passes(LANES, 4);
  localparam int W = 8 * LANES;
  state_t r_state, w_next;
  logic [3:0] r_pass;
  logic [127:0] r_buf, r_acc, w_acc;
  logic [6:0] w_base;
  logic [W-1:0] w_sb_out;
  logic w_last, w_kw_win, w_idle;
  logic r_st_done, r_kw_done;
  logic [127:0] r_st_data;
  logic [31:0] r_kw_word;
`ifdef SBOX_SCHED_RR_EN
  grant_t r_last_grant;
  assign w_kw_win = !i_st_valid || r_last_grant == GRANT_ST;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_last_grant <= GRANT_ST;
    else if (o_kw_ready) r_last_grant <= GRANT_KW;
    else if (o_st_ready) r_last_grant <= GRANT_ST;
`else
  assign w_kw_win = 1'b1;
`endif
  assign w_idle = r_state == IDLE;
  assign o_kw_ready = w_idle && i_kw_valid && w_kw_win;
  assign o_st_ready = w_idle && i_st_valid && !(i_kw_valid && w_kw_win);
  assign w_last = r_pass == 4'((r_state == KW_RUN ? KW_PASSES : ST_PASSES) - 1);
  assign w_base = 7'(int'(r_pass) * W);
  sbox_lane_bank #(.LANES(LANES)) u_bank (
    .i_in (r_buf[w_base +: W]),
    .o_out(w_sb_out)
  );
  // Merge this pass's lanes into the partial result at the same byte positions
  always_comb begin
    w_acc = r_acc;
    w_acc[w_base +: W] = w_sb_out;
  end
  always_comb begin
    w_next = r_state;
    if (w_idle) w_next = o_kw_ready ? KW_RUN : o_st_ready ? ST_RUN : IDLE;
    else if (w_last) w_next = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass    <= '0;
      r_buf     <= '0;
      r_acc     <= '0;
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
      r_st_data <= '0;
      r_kw_word <= '0;
    end else begin
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
      if (o_kw_ready || o_st_ready) begin
        r_buf  <= o_kw_ready ? {96'b0, i_kw_word} : i_st_data;
        r_pass <= '0;
      end else if (!w_idle) begin
        r_acc  <= w_acc;
        r_pass <= r_pass + 4'd1;
        if (w_last && r_state == ST_RUN) begin
          r_st_done <= 1'b1;
          r_st_data <= w_acc;
        end
        if (w_last && r_state == KW_RUN) begin
          r_kw_done <= 1'b1;
          r_kw_word <= w_acc[31:0];
        end
      end
    end
  end
  assign o_st_done = r_st_done;
  assign o_kw_done = r_kw_done;
  assign o_st_data = r_st_data;
  assign o_kw_word = r_kw_word;
endmodule
